cfg_loader: RTL and testbench

Upstream driver of the tile configuration chain. Accepts 32-bit configuration words from the host over a valid/ready stream and serialises them onto the chain's `cfg_in_start`/`cfg_bit_in` pair, which feeds the first tile's `config_block`. Each chunk is tagged with a target tile ID. After the last chunk the block waits for the chain's returning start pulse and then reports completion or timeout.

---
 rtl/cfg_pkg.sv | 29 ++
 rtl/cfg_serializer.sv | 73 +++++++
 rtl/cfg_loader.sv | 163 ++++++++++++++++
 tb/tb_cfg_loader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration-chain loader: FSM states,
// header field layout and the default chunk packing.
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

package cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        WAIT  = 2'd3
    } cfg_state_e;

    localparam int HDR_ID_LSB    = 0;
    localparam int HDR_N_LSB     = 16;
    localparam int HDR_N_W       = 16;

    localparam int DEF_WORD_W    = 32;
    localparam int DEF_SHIFT_LEN = 16;
    localparam int CPW           = DEF_WORD_W / DEF_SHIFT_LEN;

    // Chunks carried by one host word for a given word/chunk geometry.
    function automatic int chunksPerWord(input int wordW, input int shiftLen);
        return wordW / shiftLen;
    endfunction

endpackage

// File: rtl/cfg_serializer.sv
// Serialises one chunk (ID bits then payload bits, both LSB-first) onto a
// single bit line, with a start strobe on the first bit. A new load on the
// cycle flagged by last_o continues with no gap between chunks.
module cfg_serializer #(
    parameter int ID_WIDTH  = 8,
    parameter int SHIFT_LEN = 16
) (
    input  logic                 clk,
    input  logic                 crst,
    input  logic                 load_i,
    input  logic [ID_WIDTH-1:0]  id_i,
    input  logic [SHIFT_LEN-1:0] data_i,
    output logic                 start_o,
    output logic                 bit_o,
    output logic                 last_o
);

    localparam int TOTAL = ID_WIDTH + SHIFT_LEN;
    localparam int CW    = $clog2(TOTAL);
    localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);

    logic [TOTAL-1:0] shQ, shD;
    logic [CW-1:0]    cntQ, cntD;
    logic             activeQ, activeD;
    logic             startQ, startD;
    logic             bitQ, bitD;

    assign last_o  = activeQ && (cntQ == LAST_IDX);
    assign start_o = startQ;
    assign bit_o   = bitQ;

    // Next-state: a load presents ID[0] immediately and keeps the rest queued;
    // otherwise shift until the last bit, then drive the line low.
    always_comb begin
        shD     = shQ;
        cntD    = cntQ;
        activeD = activeQ;
        startD  = 1'b0;
        bitD    = 1'b0;
        if (load_i) begin
            shD     = {data_i, id_i} >> 1;
            bitD    = id_i[0];
            startD  = 1'b1;
            cntD    = '0;
            activeD = 1'b1;
        end else if (activeQ && !last_o) begin
            bitD = shQ[0];
            shD  = shQ >> 1;
            cntD = cntQ + 1'b1;
        end else begin
            activeD = 1'b0;
            cntD    = '0;
        end
    end

    // Serializer registers; the output bit and strobe are registered here.
    always_ff @(posedge clk or posedge crst) begin
        if (crst) begin
            shQ     <= '0;
            cntQ    <= '0;
            activeQ <= 1'b0;
            startQ  <= 1'b0;
            bitQ    <= 1'b0;
        end else begin
            shQ     <= shD;
            cntQ    <= cntD;
            activeQ <= activeD;
            startQ  <= startD;
            bitQ    <= bitD;
        end
    end

endmodule

// File: rtl/cfg_loader.sv
// Host-side driver of the tile configuration chain: takes a header word and
// packed payload words over valid/ready, serialises each chunk tagged with the
// target tile ID, then waits for the chain's returning start pulse.
module cfg_loader
    import cfg_pkg::*;
#(
    parameter int ID_WIDTH  = `ID_WIDTH,
    parameter int SHIFT_LEN = 16,
    parameter int WORD_W    = 32,
    parameter int TIMEOUT   = 4096
) (
    input  logic              clk,
    input  logic              crst,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cfg_in_start,
    output logic              cfg_bit_in,
    input  logic              chain_ret_start,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int WORD_CHUNKS = chunksPerWord(WORD_W, SHIFT_LEN);
    localparam int WLW         = $clog2(WORD_CHUNKS + 1);
    localparam int TW          = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);

    cfg_state_e           stateQ, stateD;
    logic                 readyQ, readyD;
    logic [ID_WIDTH-1:0]  idQ, idD;
    logic [HDR_N_W-1:0]   chunkCntQ, chunkCntD;
    logic [WORD_W-1:0]    wordQ, wordD;
    logic [WLW-1:0]       wordLeftQ, wordLeftD;
    logic [TW-1:0]        tmoQ, tmoD;
    logic                 doneQ, doneD;
    logic                 errQ, errD;

    logic                 hs;
    logic                 serLoad;
    logic [SHIFT_LEN-1:0] serData;
    logic                 serLast;
    logic [HDR_N_W-1:0]   hdrN;
    logic [ID_WIDTH-1:0]  hdrId;

    assign hs    = in_valid && readyQ;
    assign hdrN  = in_data[HDR_N_LSB +: HDR_N_W];
    assign hdrId = in_data[HDR_ID_LSB +: ID_WIDTH];

    assign in_ready = readyQ;
    assign busy     = (stateQ != IDLE);
    assign done     = doneQ;
    assign err      = errQ;

    cfg_serializer #(
        .ID_WIDTH  (ID_WIDTH),
        .SHIFT_LEN (SHIFT_LEN)
    ) u_ser (
        .clk     (clk),
        .crst    (crst),
        .load_i  (serLoad),
        .id_i    (idQ),
        .data_i  (serData),
        .start_o (cfg_in_start),
        .bit_o   (cfg_bit_in),
        .last_o  (serLast)
    );

    // Frame FSM: header decode, word intake, chunk sequencing and return wait.
    // The remaining chunks of a word sit right-justified in wordQ.
    always_comb begin
        stateD    = stateQ;
        idD       = idQ;
        chunkCntD = chunkCntQ;
        wordD     = wordQ;
        wordLeftD = wordLeftQ;
        tmoD      = tmoQ;
        doneD     = 1'b0;
        errD      = errQ;
        serLoad   = 1'b0;
        serData   = wordQ[SHIFT_LEN-1:0];
        case (stateQ)
            IDLE: begin
                if (hs) begin
                    idD       = hdrId;
                    chunkCntD = hdrN;
                    errD      = 1'b0;
                    if (hdrN == '0) begin
                        doneD = 1'b1;
                    end else begin
                        stateD = LOAD;
                    end
                end
            end
            LOAD: begin
                if (hs) begin
                    serLoad   = 1'b1;
                    serData   = in_data[SHIFT_LEN-1:0];
                    wordD     = in_data >> SHIFT_LEN;
                    wordLeftD = WLW'(WORD_CHUNKS - 1);
                    chunkCntD = chunkCntQ - 1'b1;
                    stateD    = SHIFT;
                end
            end
            SHIFT: begin
                if (serLast) begin
                    if (chunkCntQ == '0) begin
                        stateD = WAIT;
                        tmoD   = '0;
                    end else if (wordLeftQ != '0) begin
                        serLoad   = 1'b1;
                        serData   = wordQ[SHIFT_LEN-1:0];
                        wordD     = wordQ >> SHIFT_LEN;
                        wordLeftD = wordLeftQ - 1'b1;
                        chunkCntD = chunkCntQ - 1'b1;
                    end else begin
                        stateD = LOAD;
                    end
                end
            end
            WAIT: begin
                if (chain_ret_start) begin
                    doneD  = 1'b1;
                    stateD = IDLE;
                end else if (tmoQ == TMO_MAX) begin
                    errD   = 1'b1;
                    stateD = IDLE;
                end else begin
                    tmoD = tmoQ + 1'b1;
                end
            end
            default: stateD = IDLE;
        endcase
        readyD = (stateD == IDLE) || (stateD == LOAD);
    end

    // Control registers; in_ready is registered so it stays low under reset.
    always_ff @(posedge clk or posedge crst) begin
        if (crst) begin
            stateQ    <= IDLE;
            readyQ    <= 1'b0;
            idQ       <= '0;
            chunkCntQ <= '0;
            wordQ     <= '0;
            wordLeftQ <= '0;
            tmoQ      <= '0;
            doneQ     <= 1'b0;
            errQ      <= 1'b0;
        end else begin
            stateQ    <= stateD;
            readyQ    <= readyD;
            idQ       <= idD;
            chunkCntQ <= chunkCntD;
            wordQ     <= wordD;
            wordLeftQ <= wordLeftD;
            tmoQ      <= tmoD;
            doneQ     <= doneD;
            errQ      <= errD;
        end
    end

endmodule

// File: tb/tb_cfg_loader.sv
// Directed bench for cfg_loader: single-chunk frame, multi-word frame with a
// stalled host, empty frame, return timeout, and reset in mid-chunk.
module tb_cfg_loader;

    localparam int IDW = 8;
    localparam int SL  = 16;
    localparam int WW  = 32;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          crst;
    logic [WW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          cfg_in_start;
    logic          cfg_bit_in;
    logic          chain_ret_start;
    logic          busy;
    logic          done;
    logic          err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cfg_loader #(
        .ID_WIDTH  (IDW),
        .SHIFT_LEN (SL),
        .WORD_W    (WW),
        .TIMEOUT   (TMO)
    ) dut (
        .clk             (clk),
        .crst            (crst),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .cfg_in_start    (cfg_in_start),
        .cfg_bit_in      (cfg_bit_in),
        .chain_ret_start (chain_ret_start),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [WW-1:0] data, input logic valid, input logic ret);
        in_data         = data;
        in_valid        = valid;
        chain_ret_start = ret;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Checks one full chunk window starting with its first bit currently visible.
    task automatic shiftChunk(input logic [IDW-1:0] id, input logic [SL-1:0] pay, input string tag);
        logic [IDW+SL-1:0] s;
        s = {pay, id};
        for (int i = 0; i < IDW + SL; i++) begin
            checkOutput({tag, "_start"}, {31'd0, cfg_in_start}, {31'd0, (i == 0)});
            checkOutput({tag, "_bit"}, {31'd0, cfg_bit_in}, {31'd0, s[i]});
            checkOutput({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
            tick();
        end
    endtask

    initial begin
        logic [IDW+SL-1:0] rs;

        applyStimulus('0, 1'b0, 1'b0);
        crst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_start", {31'd0, cfg_in_start}, 32'd0);
        checkOutput("rst_bit", {31'd0, cfg_bit_in}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);
        crst = 1'b0;
        tick();
        checkOutput("post_rst_ready", {31'd0, in_ready}, 32'd1);

        // Frame 1: ID=7, N=1, payload 0xA5C3.
        applyStimulus(32'h0001_0007, 1'b1, 1'b0);
        tick();
        checkOutput("f1_load_busy", {31'd0, busy}, 32'd1);
        checkOutput("f1_load_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("f1_load_bit", {31'd0, cfg_bit_in}, 32'd0);
        applyStimulus(32'h0000_A5C3, 1'b1, 1'b0);
        tick();
        applyStimulus('0, 1'b0, 1'b0);
        shiftChunk(8'h07, 16'hA5C3, "f1");
        checkOutput("f1_wait_bit", {31'd0, cfg_bit_in}, 32'd0);
        checkOutput("f1_wait_start", {31'd0, cfg_in_start}, 32'd0);
        checkOutput("f1_wait_busy", {31'd0, busy}, 32'd1);
        checkOutput("f1_wait_done", {31'd0, done}, 32'd0);
        applyStimulus('0, 1'b0, 1'b1);
        tick();
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("f1_done", {31'd0, done}, 32'd1);
        checkOutput("f1_idle_busy", {31'd0, busy}, 32'd0);
        tick();
        checkOutput("f1_done_clear", {31'd0, done}, 32'd0);

        // Frame 2: ID=0x42, N=3, two words with a host stall before the second.
        applyStimulus(32'h0003_0042, 1'b1, 1'b0);
        tick();
        applyStimulus(32'h1111_2222, 1'b1, 1'b0);
        tick();
        applyStimulus('0, 1'b0, 1'b0);
        shiftChunk(8'h42, 16'h2222, "f2c0");
        shiftChunk(8'h42, 16'h1111, "f2c1");
        checkOutput("f2_load_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("f2_load_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("f2_stall_bit", {31'd0, cfg_bit_in}, 32'd0);
            checkOutput("f2_stall_start", {31'd0, cfg_in_start}, 32'd0);
            tick();
        end
        applyStimulus(32'h0000_3333, 1'b1, 1'b0);
        tick();
        applyStimulus('0, 1'b0, 1'b0);
        shiftChunk(8'h42, 16'h3333, "f2c2");
        for (int i = 0; i < 3; i++) begin
            checkOutput("f2_drop_start", {31'd0, cfg_in_start}, 32'd0);
            checkOutput("f2_drop_bit", {31'd0, cfg_bit_in}, 32'd0);
            checkOutput("f2_wait_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        applyStimulus('0, 1'b0, 1'b1);
        tick();
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("f2_done", {31'd0, done}, 32'd1);
        checkOutput("f2_idle_busy", {31'd0, busy}, 32'd0);
        tick();

        // Empty frame: N=0.
        applyStimulus(32'h0000_0005, 1'b1, 1'b0);
        tick();
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("n0_done", {31'd0, done}, 32'd1);
        checkOutput("n0_busy", {31'd0, busy}, 32'd0);
        checkOutput("n0_start", {31'd0, cfg_in_start}, 32'd0);
        checkOutput("n0_ready", {31'd0, in_ready}, 32'd1);
        tick();
        checkOutput("n0_done_clear", {31'd0, done}, 32'd0);

        // Timeout: chain never returns.
        applyStimulus(32'h0001_0003, 1'b1, 1'b0);
        tick();
        applyStimulus(32'h0000_BEEF, 1'b1, 1'b0);
        tick();
        applyStimulus('0, 1'b0, 1'b0);
        shiftChunk(8'h03, 16'hBEEF, "to");
        repeat (TMO - 1) tick();
        checkOutput("to_pre_err", {31'd0, err}, 32'd0);
        checkOutput("to_pre_busy", {31'd0, busy}, 32'd1);
        tick();
        checkOutput("to_err", {31'd0, err}, 32'd1);
        checkOutput("to_no_done", {31'd0, done}, 32'd0);
        checkOutput("to_busy", {31'd0, busy}, 32'd0);
        tick();
        checkOutput("to_err_sticky", {31'd0, err}, 32'd1);
        applyStimulus(32'h0000_0009, 1'b1, 1'b0);
        tick();
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("to_err_clear", {31'd0, err}, 32'd0);
        checkOutput("to_hdr_done", {31'd0, done}, 32'd1);
        tick();

        // Reset at chunk bit 10, then a fresh frame.
        applyStimulus(32'h0001_005A, 1'b1, 1'b0);
        tick();
        applyStimulus(32'h0000_1234, 1'b1, 1'b0);
        tick();
        applyStimulus('0, 1'b0, 1'b0);
        rs = {16'h1234, 8'h5A};
        for (int i = 0; i < 10; i++) begin
            checkOutput("cr_bit", {31'd0, cfg_bit_in}, {31'd0, rs[i]});
            tick();
        end
        checkOutput("cr_busy_before", {31'd0, busy}, 32'd1);
        crst = 1'b1;
        #1;
        checkOutput("cr_start", {31'd0, cfg_in_start}, 32'd0);
        checkOutput("cr_bit0", {31'd0, cfg_bit_in}, 32'd0);
        checkOutput("cr_busy", {31'd0, busy}, 32'd0);
        checkOutput("cr_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("cr_done", {31'd0, done}, 32'd0);
        checkOutput("cr_err", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;
        crst = 1'b0;
        tick();
        checkOutput("cr_post_ready", {31'd0, in_ready}, 32'd1);
        applyStimulus(32'h0001_0081, 1'b1, 1'b0);
        tick();
        applyStimulus(32'h0000_8001, 1'b1, 1'b0);
        tick();
        applyStimulus('0, 1'b0, 1'b0);
        shiftChunk(8'h81, 16'h8001, "cr_f");
        applyStimulus('0, 1'b0, 1'b1);
        tick();
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("cr_f_done", {31'd0, done}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
